lock_sequencer: RTL and testbench

Control core for the button combination lock. It sits between the raw `btn_0`/`btn_1` inputs and the `unlock` output. It detects and qualifies button presses, rejects illegal overlapping presses, and collects a `CODE_LEN`-digit code. It then compares the code, holds the lock open for a fixed window, and enforces a lockout after repeated failures.

---
 rtl/lock_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Button combination lock control core: qualifies presses on two digit buttons,
// collects a code, compares it, and manages the open window and failure lockout.
module lock_sequencer #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1001,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  OPEN_CYCLES    = 8,
    parameter int                  LOCKOUT_CYCLES = 16,
    parameter int                  TIMEOUT_CYCLES = 32,
    localparam int                 DW             = $clog2(CODE_LEN + 1)
) (
    input  logic          clk,
    input  logic          btn_reset_n,
    input  logic          btn_0,
    input  logic          btn_1,
    output logic          unlock,
    output logic          err,
    output logic          locked_out,
    output logic [DW-1:0] digit_cnt,
    output logic [3:0]    fail_cnt
);

    localparam int MAX_OL = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_CY = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_CY + 1);

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic                force_q, force_d;
    logic [DW-1:0]       digit_q, digit_d;
    logic [3:0]          fail_q, fail_d;
    logic                b0_q, b1_q;
    logic                unlock_q, unlock_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic rise0_s, rise1_s, legal0_s, legal1_s, illegal_s;

    // Press qualification and next-state / counter computation.
    always_comb begin
        rise0_s   = btn_0 & ~b0_q;
        rise1_s   = btn_1 & ~b1_q;
        legal0_s  = rise0_s & ~btn_1;
        legal1_s  = rise1_s & ~btn_0;
        // Covers simultaneous rising edges too, since both levels are then high.
        illegal_s = (rise0_s & btn_1) | (rise1_s & btn_0);

        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        force_d = force_q;
        digit_d = digit_q;
        fail_d  = fail_q;
        err_d   = 1'b0;

        case (state_q)
            S_ENTRY: begin
                if (illegal_s) begin
                    force_d = 1'b1;
                    state_d = S_CHECK;
                end else if (legal0_s | legal1_s) begin
                    code_d  = {code_q[CODE_LEN-2:0], legal1_s};
                    digit_d = digit_q + DW'(1);
                    cnt_d   = CW'(TIMEOUT_CYCLES - 1);
                    if (digit_q == DW'(CODE_LEN - 1)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_ENTRY;
                    end
                end else if (digit_q != '0) begin
                    // Idle with a partial entry: abandon it once the timeout expires.
                    if (cnt_q == '0) begin
                        digit_d = '0;
                        code_d  = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end else begin
                    state_d = S_ENTRY;
                end
            end
            S_CHECK: begin
                digit_d = '0;
                code_d  = '0;
                force_d = 1'b0;
                if (!force_q && (code_q == CODE)) begin
                    fail_d  = 4'd0;
                    state_d = S_OPEN;
                    cnt_d   = CW'(OPEN_CYCLES - 1);
                end else begin
                    err_d  = 1'b1;
                    fail_d = (fail_q == 4'd15) ? 4'd15 : (fail_q + 4'd1);
                    if (fail_d == 4'(MAX_FAIL)) begin
                        state_d = S_LOCKOUT;
                        cnt_d   = CW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = S_ENTRY;
                    end
                end
            end
            S_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = S_ENTRY;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = S_ENTRY;
                    fail_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_ENTRY;
            end
        endcase

        unlock_d = (state_d == S_OPEN);
        locked_d = (state_d == S_LOCKOUT);
    end

    // State, counters, edge registers and registered outputs.
    always_ff @(posedge clk or negedge btn_reset_n) begin
        if (!btn_reset_n) begin
            state_q  <= S_ENTRY;
            cnt_q    <= '0;
            code_q   <= '0;
            force_q  <= 1'b0;
            digit_q  <= '0;
            fail_q   <= 4'd0;
            b0_q     <= 1'b1;
            b1_q     <= 1'b1;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            force_q  <= force_d;
            digit_q  <= digit_d;
            fail_q   <= fail_d;
            b0_q     <= btn_0;
            b1_q     <= btn_1;
            unlock_q <= unlock_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign unlock     = unlock_q;
    assign locked_out = locked_q;
    assign err        = err_q;
    assign digit_cnt  = digit_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Table-driven bench for lock_sequencer: each record gives the inputs for one clock
// edge and the outputs expected after it; reset corner cases are hand-written.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       btn_reset_n;
    logic       btn_0;
    logic       btn_1;
    logic       unlock;
    logic       err;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic [3:0] fail_cnt;

    typedef struct {
        bit    rst;
        bit    b0;
        bit    b1;
        bit    u;
        bit    e;
        bit    l;
        int    d;
        int    f;
        string tag;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lock_sequencer dut (
        .clk        (clk),
        .btn_reset_n(btn_reset_n),
        .btn_0      (btn_0),
        .btn_1      (btn_1),
        .unlock     (unlock),
        .err        (err),
        .locked_out (locked_out),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input bit rst, input bit b0, input bit b1, input bit u, input bit e,
                       input bit l, input int d, input int f, input string tag);
        vec_t v;
        v.rst = rst; v.b0 = b0; v.b1 = b1;
        v.u = u; v.e = e; v.l = l; v.d = d; v.f = f; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n, input bit u, input bit e, input bit l,
                        input int d, input int f, input string tag);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, u, e, l, d, f, tag);
    endtask

    // Enters four digits from an empty entry, then the CHECK-exit record.
    task automatic enter(input logic [3:0] code, input int f0, input bit u, input bit e,
                         input bit l, input int f1, input string tag);
        logic [3:0] c;
        bit         dg;
        c = code;
        for (int i = 0; i < 4; i++) begin
            dg = c[3-i];
            add(1'b0, ~dg, dg, 1'b0, 1'b0, 1'b0, i + 1, f0, tag);
            if (i < 3) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i + 1, f0, tag);
        end
        add(1'b0, 1'b0, 1'b0, u, e, l, 0, f1, tag);
    endtask

    task automatic check(input string tag, input int idx, input bit u, input bit e,
                         input bit l, input int d, input int f);
        n_cmp++;
        if (unlock !== u || err !== e || locked_out !== l ||
            digit_cnt !== 3'(d) || fail_cnt !== 4'(f)) begin
            n_bad++;
            $display("FAIL %s #%0d: got u=%b e=%b l=%b d=%0d f=%0d, want u=%b e=%b l=%b d=%0d f=%0d",
                     tag, idx, unlock, err, locked_out, digit_cnt, fail_cnt, u, e, l, d, f);
        end
    endtask

    task automatic step(input bit rst, input bit b0, input bit b1, input bit u, input bit e,
                        input bit l, input int d, input int f, input string tag, input int idx);
        btn_reset_n = rst ? 1'b0 : 1'b1;
        btn_0       = b0;
        btn_1       = b1;
        @(posedge clk);
        @(negedge clk);
        check(tag, idx, u, e, l, d, f);
    endtask

    initial begin
        btn_reset_n = 1'b0;
        btn_0       = 1'b0;
        btn_1       = 1'b0;

        // Correct code, press ignored while open, exact 8-cycle window.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "idle");
        enter(4'b1001, 0, 1'b1, 1'b0, 1'b0, 0, "good_code");
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "open_press");
        idle(6, 1'b1, 1'b0, 1'b0, 0, 0, "open_hold");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "open_end");

        // Wrong code: single-cycle err.
        enter(4'b1111, 0, 1'b0, 1'b1, 1'b0, 1, "bad_code");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 1, "err_drop");

        // Illegal overlap while btn_1 is held.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "idle");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "ovl_b1");
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "ovl_first");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, "ovl_err1");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, "ovl_hold");
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, "ovl_second");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, "ovl_err2");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, "ovl_release");

        // Lockout after three failures; correct code during lockout ignored.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "idle");
        enter(4'b1111, 0, 1'b0, 1'b1, 1'b0, 1, "fail1");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 1, "fail1_idle");
        enter(4'b1111, 1, 1'b0, 1'b1, 1'b0, 2, "fail2");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 2, "fail2_idle");
        enter(4'b1111, 2, 1'b0, 1'b1, 1'b1, 3, "fail3");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, "lk_press");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, "lk_gap");
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, "lk_press");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, "lk_gap");
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, "lk_press");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, "lk_gap");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, "lk_press");
        idle(8, 1'b0, 1'b0, 1'b1, 0, 3, "lk_hold");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "lk_exit");
        enter(4'b1001, 0, 1'b1, 1'b0, 1'b0, 0, "post_lk_code");
        idle(7, 1'b1, 1'b0, 1'b0, 0, 0, "post_lk_open");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "post_lk_end");

        // Timeout: partial entry abandoned after exactly 32 idle cycles.
        enter(4'b1111, 0, 1'b0, 1'b1, 1'b0, 1, "to_fail");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 1, "to_idle");
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, "to_d1");
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, "to_gap");
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, "to_d2");
        idle(31, 1'b0, 1'b0, 1'b0, 2, 1, "to_wait");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 1, "to_expire");
        enter(4'b1001, 1, 1'b1, 1'b0, 1'b0, 0, "to_code");
        idle(7, 1'b1, 1'b0, 1'b0, 0, 0, "to_open");
        idle(1, 1'b0, 1'b0, 1'b0, 0, 0, "to_end");

        // Into OPEN for three cycles before the asynchronous reset below.
        enter(4'b1001, 0, 1'b1, 1'b0, 1'b0, 0, "rst_code");
        idle(2, 1'b1, 1'b0, 1'b0, 0, 0, "rst_open");

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].b0, vecs[i].b1, vecs[i].u, vecs[i].e, vecs[i].l,
                 vecs[i].d, vecs[i].f, vecs[i].tag, i);
        end

        // Reset mid-OPEN must clear outputs without a clock edge.
        btn_reset_n = 1'b0;
        #1;
        check("async_reset", 0, 1'b0, 1'b0, 1'b0, 0, 0);
        btn_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_held", 0, 1'b0, 1'b0, 1'b0, 0, 0);

        // btn_1 held across reset release is not a press until released.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "held_b1", 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "held_b1", 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "held_b1", 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "released", 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "repress", 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, "repress_gap", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
